// File: rtl/grf_pkg.sv
// Shared constants and helpers for the scoreboarded general register file.
// Holds default widths, the default register count and the port slice helper.
package grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_NREG   = 2 ** GRF_ADDR_W;

    // Bit offset of port k inside a flattened bus of w-bit fields.
    function automatic int port_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/grf_sb_rdport.sv
// One read port of the register file: write bypass mux plus RAW hazard term.
// Ports: ra (read address), rf_data (stored value of ra), pend (pending bit of
// ra), we0/wa0/wd0 and we1/wa1/wd1 (this cycle's writes), rd (data), haz.
import grf_pkg::*;

module grf_sb_rdport #(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              pend,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd,
    output logic              haz
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = (ra == '0);
    assign hit0    = we0 && (wa0 == ra);
    assign hit1    = we1 && (wa1 == ra);

    // Port 1 has priority, matching the storage write order.
    always_comb begin
        rd = rf_data;
        if (is_zero) begin
            rd = '0;
        end else if (hit1) begin
            rd = wd1;
        end else if (hit0) begin
            rd = wd0;
        end
    end

    // A write landing this cycle resolves the hazard via the bypass.
    assign haz = pend && !is_zero && !hit0 && !hit1;

endmodule

// File: rtl/grf_sb.sv
// Parametrised general register file with two write ports, write-to-read
// bypass and a per-register pending-write scoreboard with issue handshake.
// Ports: Rclk, Rreset (sync, active-high); RA/RD/RHAZ read ports (NRD wide);
// WE0/WA0/WD0 writeback port, WE1/WA1/WD1 mult/div port; ISS_V/ISS_A in,
// ISS_R out issue handshake; PEND_CNT pending count; GRFPC trace PC.
// Optional macro GRF_TRACE_EN enables a $display trace of effective writes.
import grf_pkg::*;

module grf_sb #(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NRD    = 2
) (
    input  logic                  Rclk,
    input  logic                  Rreset,
    input  logic [NRD*ADDR_W-1:0] RA,
    output logic [NRD*DATA_W-1:0] RD,
    output logic [NRD-1:0]        RHAZ,
    input  logic                  WE0,
    input  logic [ADDR_W-1:0]     WA0,
    input  logic [DATA_W-1:0]     WD0,
    input  logic                  WE1,
    input  logic [ADDR_W-1:0]     WA1,
    input  logic [DATA_W-1:0]     WD1,
    input  logic                  ISS_V,
    input  logic [ADDR_W-1:0]     ISS_A,
    output logic                  ISS_R,
    output logic [ADDR_W:0]       PEND_CNT,
    input  logic [31:0]           GRFPC
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_next;
    logic [ADDR_W:0]   cnt_next;
    logic              wr0_eff;
    logic              wr1_eff;
    logic              iss_hit;
    logic              accept;

    assign wr0_eff = WE0 && (WA0 != '0);
    assign wr1_eff = WE1 && (WA1 != '0);

    assign iss_hit = (WE0 && (WA0 == ISS_A)) || (WE1 && (WA1 == ISS_A));
    assign ISS_R   = (ISS_A == '0) || !pend_q[ISS_A] || iss_hit;
    assign accept  = ISS_V && ISS_R;

    // Clears first, then the issue set, so issue wins on the same address.
    always_comb begin
        pend_next = pend_q;
        if (wr0_eff) begin
            pend_next[WA0] = 1'b0;
        end
        if (wr1_eff) begin
            pend_next[WA1] = 1'b0;
        end
        if (accept && (ISS_A != '0)) begin
            pend_next[ISS_A] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(pend_next[i]);
        end
    end

    always_ff @(posedge Rclk) begin
        if (Rreset) begin
            pend_q   <= '0;
            PEND_CNT <= '0;
        end else begin
            pend_q   <= pend_next;
            PEND_CNT <= cnt_next;
        end
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge Rclk) begin
        if (Rreset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_eff) begin
                regs[WA0] <= WD0;
            end
            if (wr1_eff) begin
                regs[WA1] <= WD1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;

        assign ra_k = RA[port_off(k, ADDR_W) +: ADDR_W];

        grf_sb_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .ra      (ra_k),
            .rf_data (regs[ra_k]),
            .pend    (pend_q[ra_k]),
            .we0     (WE0),
            .wa0     (WA0),
            .wd0     (WD0),
            .we1     (WE1),
            .wa1     (WA1),
            .wd1     (WD1),
            .rd      (RD[port_off(k, DATA_W) +: DATA_W]),
            .haz     (RHAZ[k])
        );
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge Rclk) begin
        if (!Rreset) begin
            if (wr0_eff && !(WE1 && (WA1 == WA0))) begin
                $display("%0t@%h: $%0d <= %h", $time, GRFPC, WA0, WD0);
            end
            if (wr1_eff) begin
                $display("%0t@%h: $%0d <= %h", $time, GRFPC, WA1, WD1);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^GRFPC;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// Directed self-checking bench for grf_sb with default parameters.
// Inputs change 1ns after each rising edge; outputs are checked before the next.
module tb_grf_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              Rclk;
    logic              Rreset;
    logic [NR*AW-1:0]  RA;
    logic [NR*DW-1:0]  RD;
    logic [NR-1:0]     RHAZ;
    logic              WE0;
    logic [AW-1:0]     WA0;
    logic [DW-1:0]     WD0;
    logic              WE1;
    logic [AW-1:0]     WA1;
    logic [DW-1:0]     WD1;
    logic              ISS_V;
    logic [AW-1:0]     ISS_A;
    logic              ISS_R;
    logic [AW:0]       PEND_CNT;
    logic [31:0]       GRFPC;

    int checks = 0;
    int errors = 0;

    grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .Rclk     (Rclk),
        .Rreset   (Rreset),
        .RA       (RA),
        .RD       (RD),
        .RHAZ     (RHAZ),
        .WE0      (WE0),
        .WA0      (WA0),
        .WD0      (WD0),
        .WE1      (WE1),
        .WA1      (WA1),
        .WD1      (WD1),
        .ISS_V    (ISS_V),
        .ISS_A    (ISS_A),
        .ISS_R    (ISS_R),
        .PEND_CNT (PEND_CNT),
        .GRFPC    (GRFPC)
    );

    initial Rclk = 1'b0;
    always #5 Rclk = ~Rclk;

    task automatic tick();
        @(posedge Rclk);
        #1;
    endtask

    task automatic idle();
        Rreset = 1'b0;
        WE0 = 1'b0; WA0 = '0; WD0 = '0;
        WE1 = 1'b0; WA1 = '0; WD1 = '0;
        ISS_V = 1'b0; ISS_A = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RA = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        idle();
        Rreset = 1'b1;
        set_ra(5'd0, 5'd0);
        tick();
        idle();
        #1;
        checks++;
        if (PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL reset_init_cnt: got %0d want 0", PEND_CNT);
        end
        WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'h1234;
        ISS_V = 1'b1; ISS_A = 5'd6;
        tick();
        idle();
        set_ra(5'd5, 5'd6);
        checks++;
        if (RD[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL pre_reset_rd: got %h want 00001234", RD[31:0]);
        end
        checks++;
        if (RHAZ !== 2'b10 || PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL pre_reset_pend: got haz=%b cnt=%0d want 10/1", RHAZ, PEND_CNT);
        end
        Rreset = 1'b1;
        WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hFFFF;
        ISS_V = 1'b1; ISS_A = 5'd7;
        tick();
        idle();
        set_ra(5'd5, 5'd7);
        checks++;
        if (RD[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd: got %h want 00000000", RD[31:0]);
        end
        checks++;
        if (PEND_CNT !== 6'd0 || RHAZ !== 2'b00) begin
            errors++;
            $display("FAIL reset_pend: got cnt=%0d haz=%b want 0/00", PEND_CNT, RHAZ);
        end
        set_ra(5'd6, 5'd6);
        checks++;
        if (RHAZ !== 2'b00) begin
            errors++;
            $display("FAIL reset_haz6: got %b want 00", RHAZ);
        end
    endtask

    task automatic test_bypass();
        idle();
        WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'hDEAD_BEEF;
        set_ra(5'd3, 5'd3);
        checks++;
        if (RD !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL bypass_rd: got %h want deadbeefdeadbeef", RD);
        end
        tick();
        idle();
        set_ra(5'd3, 5'd0);
        checks++;
        if (RD !== {32'h0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL stored_rd: got %h want 00000000deadbeef", RD);
        end
        WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'hFFFF_FFFF;
        set_ra(5'd0, 5'd0);
        checks++;
        if (RD !== 64'h0) begin
            errors++;
            $display("FAIL zero_bypass: got %h want 0", RD);
        end
        tick();
        idle();
        set_ra(5'd0, 5'd3);
        checks++;
        if (RD !== {32'hDEAD_BEEF, 32'h0}) begin
            errors++;
            $display("FAIL zero_stored: got %h want deadbeef00000000", RD);
        end
    endtask

    task automatic test_collision();
        idle();
        WE0 = 1'b1; WA0 = 5'd7; WD0 = 32'h11;
        WE1 = 1'b1; WA1 = 5'd7; WD1 = 32'h22;
        set_ra(5'd7, 5'd0);
        checks++;
        if (RD[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL coll_bypass: got %h want 00000022", RD[31:0]);
        end
        tick();
        idle();
        set_ra(5'd0, 5'd7);
        checks++;
        if (RD[63:32] !== 32'h22) begin
            errors++;
            $display("FAIL coll_stored: got %h want 00000022", RD[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        ISS_V = 1'b1; ISS_A = 5'd9;
        #1;
        checks++;
        if (ISS_R !== 1'b1) begin
            errors++;
            $display("FAIL iss9_ready: got %b want 1", ISS_R);
        end
        tick();
        idle();
        set_ra(5'd9, 5'd0);
        checks++;
        if (RHAZ !== 2'b01 || PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL iss9_pend: got haz=%b cnt=%0d want 01/1", RHAZ, PEND_CNT);
        end
        ISS_V = 1'b1; ISS_A = 5'd9;
        #1;
        checks++;
        if (ISS_R !== 1'b0) begin
            errors++;
            $display("FAIL iss9_refuse: got %b want 0", ISS_R);
        end
        tick();
        idle();
        #1;
        checks++;
        if (PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL refuse_cnt: got %0d want 1", PEND_CNT);
        end
        WE1 = 1'b1; WA1 = 5'd9; WD1 = 32'h99;
        set_ra(5'd9, 5'd0);
        checks++;
        if (RHAZ !== 2'b00 || RD[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL wr9_clear: got haz=%b rd=%h want 00/00000099", RHAZ, RD[31:0]);
        end
        tick();
        idle();
        set_ra(5'd9, 5'd9);
        checks++;
        if (PEND_CNT !== 6'd0 || RHAZ !== 2'b00) begin
            errors++;
            $display("FAIL wr9_cnt: got cnt=%0d haz=%b want 0/00", PEND_CNT, RHAZ);
        end
    endtask

    task automatic test_issue_write();
        idle();
        ISS_V = 1'b1; ISS_A = 5'd4;
        tick();
        idle();
        WE0 = 1'b1; WA0 = 5'd4; WD0 = 32'h44;
        ISS_V = 1'b1; ISS_A = 5'd4;
        #1;
        checks++;
        if (ISS_R !== 1'b1 || PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL iw_ready: got r=%b cnt=%0d want 1/1", ISS_R, PEND_CNT);
        end
        tick();
        idle();
        set_ra(5'd4, 5'd0);
        checks++;
        if (RD[31:0] !== 32'h44 || RHAZ !== 2'b01 || PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL iw_after: got rd=%h haz=%b cnt=%0d want 00000044/01/1",
                     RD[31:0], RHAZ, PEND_CNT);
        end
        WE0 = 1'b1; WA0 = 5'd4; WD0 = 32'h45;
        tick();
        idle();
        #1;
        checks++;
        if (PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL iw_clear: got %0d want 0", PEND_CNT);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int a = 1; a < 32; a++) begin
            ISS_V = 1'b1; ISS_A = AW'(a);
            tick();
        end
        idle();
        #1;
        checks++;
        if (PEND_CNT !== 6'd31) begin
            errors++;
            $display("FAIL full_cnt: got %0d want 31", PEND_CNT);
        end
        ISS_V = 1'b1; ISS_A = 5'd5;
        #1;
        checks++;
        if (ISS_R !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: got %b want 0", ISS_R);
        end
        ISS_A = 5'd0;
        #1;
        checks++;
        if (ISS_R !== 1'b1) begin
            errors++;
            $display("FAIL iss0_ready: got %b want 1", ISS_R);
        end
        tick();
        idle();
        #1;
        checks++;
        if (PEND_CNT !== 6'd31) begin
            errors++;
            $display("FAIL iss0_cnt: got %0d want 31", PEND_CNT);
        end
        WE0 = 1'b1; WA0 = 5'd1; WD0 = 32'h1;
        WE1 = 1'b1; WA1 = 5'd2; WD1 = 32'h2;
        tick();
        idle();
        set_ra(5'd1, 5'd3);
        checks++;
        if (PEND_CNT !== 6'd29 || RHAZ !== 2'b10) begin
            errors++;
            $display("FAIL dual_clear: got cnt=%0d haz=%b want 29/10", PEND_CNT, RHAZ);
        end
    endtask

    initial begin
        GRFPC = 32'h0000_1000;
        RA = '0;
        idle();
        tick();
        test_reset();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_issue_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
